bip_core: RTL and testbench

- Parametrised next-generation BIP accumulator CPU.
- Drives a synchronous-read program memory and a synchronous-read/write data memory.
- Adds to the BIP I ISA: logic ops, branches, start/halt handshake, illegal-opcode flag, optional cycle counter.
- Instantiated by the BIP system top in place of the current CPU.

---
 rtl/bip_core.sv | 221 ++++++++++++++++++++++
 tb/tb_bip_core.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_core.sv
`default_nettype none
// ============================================================================
//  Module      : bip_core
//  Description : Parametrised BIP accumulator CPU. Fetches from a synchronous
//                program memory and accesses a synchronous data memory.
//                Logic ops, branches, start/halt handshake and a sticky
//                illegal-opcode flag. The optional cycle counter is enabled
//                with the macro BIP_CYCLE_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module bip_core #(
   parameter int ADDR_BITS   = 11,
   parameter int DATA_WIDTH  = 16,
   parameter int OPCODE_BITS = 5,
   parameter int CNT_BITS    = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   output logic                             busy,
   output logic                             halted,
   output logic [ADDR_BITS-1:0]             addr_program,
   input  logic [OPCODE_BITS+ADDR_BITS-1:0] data,
   output logic                             rd,
   output logic                             wr,
   output logic [ADDR_BITS-1:0]             addr_data,
   input  logic [DATA_WIDTH-1:0]            in_data,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [DATA_WIDTH-1:0]            acc,
   output logic                             illegal,
   output logic [CNT_BITS-1:0]              cycle_count
);

   // FSM encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_MEMRD  = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;

   // Opcode map
   localparam logic [OPCODE_BITS-1:0] OP_HLT  = OPCODE_BITS'(0);
   localparam logic [OPCODE_BITS-1:0] OP_STO  = OPCODE_BITS'(1);
   localparam logic [OPCODE_BITS-1:0] OP_LD   = OPCODE_BITS'(2);
   localparam logic [OPCODE_BITS-1:0] OP_LDI  = OPCODE_BITS'(3);
   localparam logic [OPCODE_BITS-1:0] OP_ADD  = OPCODE_BITS'(4);
   localparam logic [OPCODE_BITS-1:0] OP_ADDI = OPCODE_BITS'(5);
   localparam logic [OPCODE_BITS-1:0] OP_SUB  = OPCODE_BITS'(6);
   localparam logic [OPCODE_BITS-1:0] OP_SUBI = OPCODE_BITS'(7);
   localparam logic [OPCODE_BITS-1:0] OP_AND  = OPCODE_BITS'(8);
   localparam logic [OPCODE_BITS-1:0] OP_ANDI = OPCODE_BITS'(9);
   localparam logic [OPCODE_BITS-1:0] OP_OR   = OPCODE_BITS'(10);
   localparam logic [OPCODE_BITS-1:0] OP_ORI  = OPCODE_BITS'(11);
   localparam logic [OPCODE_BITS-1:0] OP_XOR  = OPCODE_BITS'(12);
   localparam logic [OPCODE_BITS-1:0] OP_XORI = OPCODE_BITS'(13);
   localparam logic [OPCODE_BITS-1:0] OP_JMP  = OPCODE_BITS'(14);
   localparam logic [OPCODE_BITS-1:0] OP_BEQ  = OPCODE_BITS'(15);
   localparam logic [OPCODE_BITS-1:0] OP_BNE  = OPCODE_BITS'(16);

   // Shared ALU for the memory-operand and immediate forms of each op;
   // the opcode of either form selects the same function.
   function automatic logic [DATA_WIDTH-1:0] alu(
      input logic [OPCODE_BITS-1:0] op,
      input logic [DATA_WIDTH-1:0]  a,
      input logic [DATA_WIDTH-1:0]  b
   );
      case (op)
         OP_LD,  OP_LDI:  alu = b;
         OP_ADD, OP_ADDI: alu = a + b;
         OP_SUB, OP_SUBI: alu = a - b;
         OP_AND, OP_ANDI: alu = a & b;
         OP_OR,  OP_ORI:  alu = a | b;
         OP_XOR, OP_XORI: alu = a ^ b;
         default:         alu = a;
      endcase
   endfunction

   logic [2:0]             state_q, state_d;
   logic [ADDR_BITS-1:0]   pc_q, pc_d;
   logic [DATA_WIDTH-1:0]  acc_q, acc_d;
   logic                   illegal_q, illegal_d;
   logic [OPCODE_BITS-1:0] op_q, op_d;

   logic [OPCODE_BITS-1:0] w_opcode;
   logic [ADDR_BITS-1:0]   w_operand;
   logic [ADDR_BITS-1:0]   w_pc_inc;
   logic [DATA_WIDTH-1:0]  w_imm_sext;
   logic [DATA_WIDTH-1:0]  w_imm_zext;
   logic [DATA_WIDTH-1:0]  w_imm;
   logic                   w_memop;
   logic                   w_is_sto;
   logic                   w_decode;
   logic                   w_busy;
   logic                   w_restart;

   assign w_opcode  = data[OPCODE_BITS+ADDR_BITS-1 -: OPCODE_BITS];
   assign w_operand = data[ADDR_BITS-1:0];
   assign w_pc_inc  = pc_q + ADDR_BITS'(1);   // wraps silently at the top

   // Operand extension; a narrow datapath simply truncates the operand
   generate
      if (DATA_WIDTH > ADDR_BITS) begin : g_imm_ext
         assign w_imm_sext = {{(DATA_WIDTH-ADDR_BITS){w_operand[ADDR_BITS-1]}}, w_operand};
         assign w_imm_zext = {{(DATA_WIDTH-ADDR_BITS){1'b0}}, w_operand};
      end else begin : g_imm_trunc
         assign w_imm_sext = w_operand[DATA_WIDTH-1:0];
         assign w_imm_zext = w_operand[DATA_WIDTH-1:0];
      end
   endgenerate

   // Logical immediates take the zero-extended operand, arithmetic ones the signed
   assign w_imm = ((w_opcode == OP_ANDI) || (w_opcode == OP_ORI) || (w_opcode == OP_XORI))
                  ? w_imm_zext : w_imm_sext;

   assign w_memop  = (w_opcode == OP_LD)  || (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                     (w_opcode == OP_AND) || (w_opcode == OP_OR)  || (w_opcode == OP_XOR);
   assign w_is_sto = (w_opcode == OP_STO);
   assign w_decode = (state_q == ST_DECODE);
   assign w_busy   = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_MEMRD);
   assign w_restart = ((state_q == ST_IDLE) || (state_q == ST_HALT)) && start;

   // Memory strobes are combinational in DECODE so the synchronous memories
   // capture address/data on the edge that ends DECODE. Reset gates them so
   // nothing lands on a reset edge.
   assign rd           = w_decode && w_memop && !reset;
   assign wr           = w_decode && w_is_sto && !reset;
   assign addr_data    = (w_decode && (w_memop || w_is_sto)) ? w_operand : '0;
   assign addr_program = pc_q;
   assign out_data     = acc_q;
   assign acc          = acc_q;
   assign illegal      = illegal_q;
   assign busy         = w_busy;
   assign halted       = (state_q == ST_HALT);

   // Next-state, pc and accumulator update
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      acc_d     = acc_q;
      illegal_d = illegal_q;
      op_d      = op_q;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d   = ST_FETCH;
               pc_d      = '0;
               acc_d     = '0;
               illegal_d = 1'b0;
            end
         end
         ST_FETCH: begin
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            op_d    = w_opcode;
            state_d = ST_FETCH;
            pc_d    = w_pc_inc;
            case (w_opcode)
               OP_HLT: begin
                  state_d = ST_HALT;
                  pc_d    = pc_q;
               end
               OP_STO: ;
               OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  state_d = ST_MEMRD;
                  pc_d    = pc_q;
               end
               OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: begin
                  acc_d = alu(w_opcode, acc_q, w_imm);
               end
               OP_JMP: pc_d = w_operand;
               OP_BEQ: if (acc_q == '0) pc_d = w_operand;
               OP_BNE: if (acc_q != '0) pc_d = w_operand;
               default: illegal_d = 1'b1;   // executes as NOP
            endcase
         end
         ST_MEMRD: begin
            acc_d   = alu(op_q, acc_q, in_data);
            pc_d    = w_pc_inc;
            state_d = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Architectural state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         acc_q     <= '0;
         illegal_q <= 1'b0;
         op_q      <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         acc_q     <= acc_d;
         illegal_q <= illegal_d;
         op_q      <= op_d;
      end
   end

`ifdef BIP_CYCLE_COUNT_EN
   logic [CNT_BITS-1:0] cnt_q;

   // Saturating count of busy cycles, cleared when a run starts
   always_ff @(posedge clk) begin
      if (reset || w_restart) begin
         cnt_q <= '0;
      end else if (w_busy && !(&cnt_q)) begin
         cnt_q <= cnt_q + CNT_BITS'(1);
      end
   end

   assign cycle_count = cnt_q;
`else
   assign cycle_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bip_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bip_core
//  Description : Scoreboard bench for bip_core. Stimulus queues the expected
//                writes, reads and halt results; a monitor compares them as
//                the core presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_core;

   localparam logic [4:0] OP_HLT  = 5'd0;
   localparam logic [4:0] OP_STO  = 5'd1;
   localparam logic [4:0] OP_LDI  = 5'd3;
   localparam logic [4:0] OP_ADDI = 5'd5;
   localparam logic [4:0] OP_SUBI = 5'd7;
   localparam logic [4:0] OP_AND  = 5'd8;
   localparam logic [4:0] OP_XORI = 5'd13;
   localparam logic [4:0] OP_JMP  = 5'd14;
   localparam logic [4:0] OP_BEQ  = 5'd15;
   localparam logic [4:0] OP_BNE  = 5'd16;
   localparam logic [4:0] OP_BAD  = 5'd31;

   typedef struct {
      logic [15:0] acc;
      logic [10:0] pc;
      logic        ill;
      int          busy;
   } halt_t;

   typedef struct {
      logic [10:0] addr;
      logic [15:0] val;
   } acc_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        halted;
   logic [10:0] addr_program;
   logic [15:0] data;
   logic        rd;
   logic        wr;
   logic [10:0] addr_data;
   logic [15:0] in_data;
   logic [15:0] out_data;
   logic [15:0] acc;
   logic        illegal;
   logic [31:0] cycle_count;

   logic [15:0] prog [0:2047];
   logic [15:0] dmem [0:2047];
   logic        pre_we;
   logic [10:0] pre_addr;
   logic [15:0] pre_val;

   halt_t exp_halt[$];
   acc_t  exp_wr[$];
   acc_t  exp_rd[$];

   int n_cmp = 0;
   int n_err = 0;
   int busy_cnt = 0;

   bip_core dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .halted       (halted),
      .addr_program (addr_program),
      .data         (data),
      .rd           (rd),
      .wr           (wr),
      .addr_data    (addr_data),
      .in_data      (in_data),
      .out_data     (out_data),
      .acc          (acc),
      .illegal      (illegal),
      .cycle_count  (cycle_count)
   );

   always #5 clk = ~clk;

   // Synchronous-read memories
   always @(posedge clk) begin
      data <= prog[addr_program];
      if (wr) dmem[addr_data] <= out_data;
      else if (pre_we) dmem[pre_addr] <= pre_val;
      if (rd) in_data <= dmem[addr_data];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] enc(input logic [4:0] op, input logic [10:0] opnd);
      return {op, opnd};
   endfunction

   // Monitor: compare whatever the core presents against the queued expectations
   initial begin
      logic prev_h;
      logic prev_rd;
      halt_t h;
      acc_t  a;
      prev_h  = 1'b0;
      prev_rd = 1'b0;
      forever begin
         @(negedge clk);
         if (start) busy_cnt = 0;
         else if (busy) busy_cnt++;
         if (rd && wr) check("rd_wr_overlap", 32'(wr), 32'd0);
         if (wr) begin
            if (exp_wr.size() == 0) check("unexpected_write", 32'(wr), 32'd0);
            else begin
               a = exp_wr.pop_front();
               check("wr_addr", 32'(addr_data), 32'(a.addr));
               check("wr_data", 32'(out_data), 32'(a.val));
            end
         end
         if (rd) begin
            check("rd_single_cycle", 32'(prev_rd), 32'd0);
            if (exp_rd.size() == 0) check("unexpected_read", 32'(rd), 32'd0);
            else begin
               a = exp_rd.pop_front();
               check("rd_addr", 32'(addr_data), 32'(a.addr));
            end
         end
         if (halted && !prev_h) begin
            if (exp_halt.size() == 0) check("unexpected_halt", 32'(halted), 32'd0);
            else begin
               h = exp_halt.pop_front();
               check("halt_acc", 32'(acc), 32'(h.acc));
               check("halt_pc", 32'(addr_program), 32'(h.pc));
               check("halt_illegal", 32'(illegal), 32'(h.ill));
               check("halt_busy_cycles", 32'(busy_cnt), 32'(h.busy));
`ifdef BIP_CYCLE_COUNT_EN
               check("halt_cycle_count", cycle_count, 32'(h.busy));
`else
               check("halt_cycle_count", cycle_count, 32'd0);
`endif
            end
         end
         prev_h  = halted;
         prev_rd = rd;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 2048; i++) prog[i] = enc(OP_HLT, 11'd0);
   endtask

   task automatic preload(input logic [10:0] ad, input logic [15:0] v);
      @(posedge clk); #1 pre_we = 1'b1; pre_addr = ad; pre_val = v;
      @(posedge clk); #1 pre_we = 1'b0;
   endtask

   task automatic start_run();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic push_halt(input logic [15:0] a, input logic [10:0] p, input logic il, input int b);
      halt_t h;
      h.acc = a; h.pc = p; h.ill = il; h.busy = b;
      exp_halt.push_back(h);
   endtask

   task automatic push_acc(input bit is_wr, input logic [10:0] ad, input logic [15:0] v);
      acc_t a;
      a.addr = ad; a.val = v;
      if (is_wr) exp_wr.push_back(a);
      else exp_rd.push_back(a);
   endtask

   task automatic run_to_halt(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (halted) done = 1'b1;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: got no halt, expected halt within 400 cycles", name);
      end
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      pre_we = 1'b0;
      pre_addr = '0;
      pre_val  = '0;
      clear_prog();
      do_reset();
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_addr_program", 32'(addr_program), 32'd0);
      check("rst_rd_wr", 32'({rd, wr}), 32'd0);
      check("rst_addr_data", 32'(addr_data), 32'd0);
      check("rst_acc", 32'(acc), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_cycle_count", cycle_count, 32'd0);

      // LDI 5; ADDI 3; STO 10; HLT
      clear_prog();
      prog[0] = enc(OP_LDI, 11'd5);
      prog[1] = enc(OP_ADDI, 11'd3);
      prog[2] = enc(OP_STO, 11'd10);
      prog[3] = enc(OP_HLT, 11'd0);
      push_acc(1'b1, 11'd10, 16'd8);
      push_halt(16'd8, 11'd3, 1'b0, 8);
      start_run();
      run_to_halt("t1");
      check("t1_mem10", 32'(dmem[10]), 32'd8);

      // Countdown loop: LDI 3; SUBI 1; BNE 1; HLT
      do_reset();
      clear_prog();
      prog[0] = enc(OP_LDI, 11'd3);
      prog[1] = enc(OP_SUBI, 11'd1);
      prog[2] = enc(OP_BNE, 11'd1);
      prog[3] = enc(OP_HLT, 11'd0);
      push_halt(16'd0, 11'd3, 1'b0, 16);
      start_run();
      run_to_halt("t2");

      // Memory operand: mem[4]=0x00F0; LDI 0xFF; AND 4; XORI 0xF; HLT
      do_reset();
      preload(11'd4, 16'h00F0);
      clear_prog();
      prog[0] = enc(OP_LDI, 11'h0FF);
      prog[1] = enc(OP_AND, 11'd4);
      prog[2] = enc(OP_XORI, 11'h00F);
      prog[3] = enc(OP_HLT, 11'd0);
      push_acc(1'b0, 11'd4, 16'h0);
      push_halt(16'h00FF, 11'd3, 1'b0, 9);
      start_run();
      run_to_halt("t3");

      // Sign extension, wrap and taken BEQ
      do_reset();
      clear_prog();
      prog[0] = enc(OP_LDI, 11'h7FF);
      prog[1] = enc(OP_ADDI, 11'd1);
      prog[2] = enc(OP_BEQ, 11'd7);
      for (int i = 3; i < 7; i++) prog[i] = enc(OP_LDI, 11'h123);
      prog[7] = enc(OP_HLT, 11'd0);
      push_halt(16'h0000, 11'd7, 1'b0, 8);
      start_run();
      run_to_halt("t4");

      // Illegal opcode at pc=2, then restart from HALT
      do_reset();
      clear_prog();
      prog[0] = enc(OP_LDI, 11'd1);
      prog[1] = enc(OP_LDI, 11'd2);
      prog[2] = enc(OP_BAD, 11'd0);
      prog[3] = enc(OP_LDI, 11'd9);
      prog[4] = enc(OP_HLT, 11'd0);
      push_halt(16'd9, 11'd4, 1'b1, 10);
      start_run();
      run_to_halt("t5a");
      push_halt(16'd9, 11'd4, 1'b1, 10);
      start_run();
      check("restart_illegal", 32'(illegal), 32'd0);
      check("restart_acc", 32'(acc), 32'd0);
      check("restart_pc", 32'(addr_program), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      run_to_halt("t5b");

      // Reset during DECODE of STO
      do_reset();
      preload(11'd12, 16'hBEEF);
      clear_prog();
      prog[0] = enc(OP_LDI, 11'd5);
      prog[1] = enc(OP_STO, 11'd12);
      prog[2] = enc(OP_HLT, 11'd0);
      start_run();
      repeat (3) @(posedge clk);
      #1;
      check("t6_sto_wr", 32'(wr), 32'd1);
      check("t6_sto_addr", 32'(addr_data), 32'd12);
      reset = 1'b1;
      #1 check("t6_wr_gated", 32'(wr), 32'd0);
      @(posedge clk); #1;
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_halted", 32'(halted), 32'd0);
      check("t6_pc", 32'(addr_program), 32'd0);
      check("t6_acc", 32'(acc), 32'd0);
      check("t6_addr_data", 32'(addr_data), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("t6_idle", 32'({busy, halted}), 32'd0);
      check("t6_mem12", 32'(dmem[12]), 32'hBEEF);

      // JMP 2047 then sequential fetch wraps to 0
      do_reset();
      clear_prog();
      prog[0]    = enc(OP_BNE, 11'd3);
      prog[1]    = enc(OP_LDI, 11'd1);
      prog[2]    = enc(OP_JMP, 11'h7FF);
      prog[3]    = enc(OP_HLT, 11'd0);
      prog[2047] = enc(OP_ADDI, 11'd1);
      push_halt(16'd2, 11'd3, 1'b0, 12);
      start_run();
      run_to_halt("t7");

      repeat (2) @(negedge clk);
      check("left_halt", exp_halt.size(), 32'd0);
      check("left_wr", exp_wr.size(), 32'd0);
      check("left_rd", exp_rd.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
